// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the rv32i fetch stage and its neighbours.
package fetch_unit_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  // Opcode field values shared with the main decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-fetch-address selection: flush over taken branch over
// sequential pc + 4, with word-alignment masking of redirect targets.
module next_pc_sel
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            take_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] raw_pc;
  logic            redirect;

  always_comb begin
    pc_plus4_o = pc_i + XLEN'(4);
    raw_pc     = pc_plus4_o;
    redirect   = 1'b0;
    if (flush_i) begin
      raw_pc   = flush_pc_i;
      redirect = 1'b1;
    end else if (take_i) begin
      raw_pc   = target_i;
      redirect = 1'b1;
    end
    // Only redirects can be misaligned; the sequential path stays word aligned.
    next_pc_o    = {raw_pc[XLEN-1:2], 2'b00};
    misaligned_o = redirect && (raw_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: PC register, single-outstanding imem reads and the
// instruction register feeding the main decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] flushPc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic            instr_valid,
  output logic            misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            drop_q, drop_d;
  logic            misaligned_q, misaligned_d;

  logic            take;
  logic [XLEN-1:0] sel_next_pc;
  logic            sel_misaligned;

  assign take = (state_q == ST_VALID) && !stall && pcSrc;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc_i        (pc_q),
    .take_i      (take),
    .target_i    (pcTarget),
    .flush_i     (flush),
    .flush_pc_i  (flushPc),
    .next_pc_o   (sel_next_pc),
    .pc_plus4_o  (pcPlus4),
    .misaligned_o(sel_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    drop_d        = drop_q;
    misaligned_d  = 1'b0;

    if (flush) begin
      fetch_pc_d    = sel_next_pc;
      instr_valid_d = 1'b0;
      misaligned_d  = sel_misaligned;
      unique case (state_q)
        ST_FETCH: begin
          // An acked request is already in flight; its response must be dropped.
          state_d = imem_ack ? ST_WAIT : ST_FETCH;
          drop_d  = imem_ack;
        end
        ST_WAIT: begin
          state_d = imem_rvalid ? ST_FETCH : ST_WAIT;
          drop_d  = !imem_rvalid;
        end
        default: begin
          state_d = ST_FETCH;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ack) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_FETCH;
            end else begin
              instr_d       = imem_rdata;
              pc_d          = fetch_pc_q;
              instr_valid_d = 1'b1;
              state_d       = ST_VALID;
            end
          end
        end
        ST_VALID: begin
          if (!stall) begin
            fetch_pc_d    = sel_next_pc;
            instr_valid_d = 1'b0;
            misaligned_d  = sel_misaligned;
            state_d       = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      drop_q        <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      drop_q        <= drop_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic, all
// checked against a transaction-level model of request/response/hold.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, pcSrc, stall, flush;
  logic [31:0] pcTarget, flushPc;
  logic        imem_req, imem_ack, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, pcPlus4;
  logic [6:0]  op;
  logic        instr_valid, misaligned;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcSrc      (pcSrc),
    .pcTarget   (pcTarget),
    .stall      (stall),
    .flush      (flush),
    .flushPc    (flushPc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .instr_valid(instr_valid),
    .misaligned (misaligned)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a request is either open (waiting for ack), in flight (waiting for
  // data, possibly to be discarded), or an instruction is being held.
  bit          m_req, m_inflight, m_discard, m_valid, m_mis;
  logic [31:0] m_addr, m_instr, m_pc;
  int          lat;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, m_addr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr", instr, m_instr);
    check("op", 32'(op), 32'(m_instr[6:0]));
    check("pc", pc, m_pc);
    check("pcPlus4", pcPlus4, m_pc + 32'd4);
    check("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  task automatic step(input logic r, input logic st, input logic ps, input logic [31:0] pt,
                      input logic fl, input logic [31:0] fp, input logic ak, input logic rv,
                      input logic [31:0] rd);
    bit acc, got;
    reset = r; stall = st; pcSrc = ps; pcTarget = pt;
    flush = fl; flushPc = fp; imem_ack = ak; imem_rvalid = rv; imem_rdata = rd;
    if (r) begin
      m_req = 1; m_addr = 32'h0; m_inflight = 0; m_discard = 0;
      m_valid = 0; m_instr = 32'h13; m_pc = 32'h0; m_mis = 0; lat = 0;
    end else begin
      acc   = m_req && ak;
      got   = m_inflight && rv;
      m_mis = 0;
      if (acc) lat = $urandom_range(0, 2);
      else if (m_inflight && !rv && lat > 0) lat--;
      if (fl) begin
        m_valid = 0;
        m_mis   = (fp[1:0] != 2'b00);
        m_addr  = align(fp);
        if (acc) begin
          m_req = 0; m_inflight = 1; m_discard = 1;
        end else if (m_inflight && !rv) begin
          m_discard = 1;
        end else begin
          m_req = 1; m_inflight = 0; m_discard = 0;
        end
      end else if (acc) begin
        m_req = 0; m_inflight = 1;
      end else if (got) begin
        m_inflight = 0;
        if (m_discard) begin
          m_discard = 0; m_req = 1;
        end else begin
          m_valid = 1; m_instr = rd; m_pc = m_addr;
        end
      end else if (m_valid && !st) begin
        m_valid = 0; m_req = 1;
        if (ps) begin
          m_addr = align(pt);
          m_mis  = (pt[1:0] != 2'b00);
        end else begin
          m_addr = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic        r, st, ps, fl, ak, rv;
    logic [31:0] pt, fp;

    // Reset and first fetch
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h13);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0050_0093);
    check("first_instr", instr, 32'h0050_0093);
    check("first_op", 32'(op), 32'(7'b0010011));
    check("first_pc4", pcPlus4, 32'h4);
    check("first_valid", 32'(instr_valid), 32'd1);

    // Sequential flow
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("seq_addr4", imem_addr, 32'h4);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0113);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("seq_addr8", imem_addr, 32'h8);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0020_8193);

    // Stall hold, then taken branch
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 32'h80, 0, 0, 0, 0, 0);
      check("stall_pc", pc, 32'h8);
    end
    step(0, 0, 1, 32'h40, 0, 0, 0, 0, 0);
    check("br_addr", imem_addr, 32'h40);
    check("br_mis", 32'(misaligned), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_006F);

    // Misaligned redirect
    step(0, 0, 1, 32'h42, 0, 0, 0, 0, 0);
    check("mis_addr", imem_addr, 32'h40);
    check("mis_pulse", 32'(misaligned), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mis_clear", 32'(misaligned), 32'd0);

    // Flush while a response is in flight
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("fl_valid", 32'(instr_valid), 32'd0);
    check("fl_addr", imem_addr, 32'h100);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0033);
    check("fl_pc", pc, 32'h100);

    // Reset during WAIT
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rstw_req", 32'(imem_req), 32'd1);
    check("rstw_instr", instr, 32'h13);

    // pc + 4 wrap
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
    check("wrap_pc4", pcPlus4, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 40);
      ps = 1'($urandom_range(0, 1));
      pt = $urandom;
      if ($urandom_range(0, 1) == 1) pt[1:0] = 2'b00;
      fl = ($urandom_range(0, 99) < 8);
      fp = $urandom;
      if ($urandom_range(0, 1) == 1) fp[1:0] = 2'b00;
      ak = m_req && ($urandom_range(0, 99) < 60);
      rv = m_inflight && (lat == 0) && ($urandom_range(0, 99) < 70);
      step(r, st, ps, pt, fl, fp, ak, rv, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the rv32i core, directly upstream of the main decoder.
- Owns the PC register and issues one-outstanding-request reads to instruction memory.
- Holds the fetched word in an instruction register and presents op = instr[6:0] to the decoder.
- Consumes the decoder's pcSrc and the datapath branch target to choose the next PC; a flush input lets the datapath redirect fetch mid-request.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pcSrc  in  1  take branch/jump for the held instruction; sampled only in VALID when stall=0.
- pcTarget  in  32  branch/jump target paired with pcSrc.
- stall  in  1  decode/execute not ready; held instruction must not be consumed.
- flush  in  1  redirect fetch to flushPc; overrides everything except reset.
- flushPc  in  32  redirect address.
- imem_req  out  1  read request valid.
- imem_addr  out  32  read address; word aligned.
- imem_ack  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- instr  out  32  instruction register.
- op  out  7  instr[6:0], to the main decoder.
- pc  out  32  address of instr.
- pcPlus4  out  32  pc + 4, used for jal writeback.
- instr_valid  out  1  instr/pc hold a live instruction.
- misaligned  out  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Behaviour:
- Reset values (synchronous):
  - state = FETCH, fetch_pc = RESET_PC.
  - instr = 32'h0000_0013 (nop), pc = RESET_PC, instr_valid = 0.
  - drop = 0, misaligned = 0.
- FSM states: FETCH, WAIT, VALID.
- FETCH:
  - imem_req = 1, imem_addr = fetch_pc.
  - imem_ack=1 -> WAIT. Otherwise stay; request and address stay stable until acked.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid with drop=0: instr <= imem_rdata, pc <= fetch_pc, go to VALID.
  - On imem_rvalid with drop=1: discard data, clear drop, go to FETCH.
- VALID:
  - instr_valid = 1, imem_req = 0.
  - stall=1: hold all state.
  - stall=0: fetch_pc <= pcSrc ? pcTarget : pc + 4, instr_valid <= 0, go to FETCH.
  - Fetch is not overlapped with decode: one instruction at a time, minimum 3 cycles per instruction with ack in FETCH and rvalid on the next cycle.
- Memory contract:
  - imem_rvalid arrives no earlier than the cycle after imem_ack.
  - At most one request is outstanding.
  - Memory shares the same reset, so no response survives reset.
- flush (highest priority after reset):
  - Sets fetch_pc <= flushPc and instr_valid <= 0.
  - From FETCH or VALID: go to FETCH.
  - From WAIT with no rvalid this cycle: set drop=1 and stay in WAIT. The response in flight is discarded and the next FETCH uses flushPc.
  - From WAIT with rvalid this cycle: the data is discarded, go to FETCH.
  - flush in FETCH while imem_ack=1: the request counts as accepted, so go to WAIT with drop=1.
- Alignment:
  - Any redirect address (pcTarget when taken, or flushPc) with [1:0] != 0 is forced to {addr[31:2], 2'b00}.
  - misaligned pulses for exactly one cycle.
- Arithmetic: pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0); no overflow flag.
- op and pcPlus4 are combinational from instr and pc.
- reset asserted in any state, including WAIT, returns to the reset values on the next edge.

Decomposition:
- Shared package holds:
  - XLEN.
  - RESET_PC default.
  - NOP_INSTR = 32'h0000_0013.
  - The fetch state encoding (FETCH=2'd0, WAIT=2'd1, VALID=2'd2).
  - The opcode constants shared with the decoder (LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011, JAL 1101111).
- One natural sub-module: next_pc_sel. It is combinational and handles pcSrc/flush priority, the +4 adder, alignment masking and misaligned generation. The FSM and registers stay in fetch_unit.

Test Plan:
- Reset, then memory acks immediately with rvalid one cycle later and rdata=32'h00500093. Expect imem_addr=0, instr=32'h00500093, op=7'b0010011, pc=0, pcPlus4=4, instr_valid=1 at cycle 3.
- Sequential flow with stall=0 and pcSrc=0 over three instructions. Expect imem_addr sequence 0, 4, 8 and instr_valid high one cycle in every three.
- Hold instr at pc=8 with stall=1 for 4 cycles. Expect instr, pc and instr_valid unchanged and imem_req=0. Then release with pcSrc=1, pcTarget=32'h40: expect the next imem_addr=32'h40.
- Redirect with pcTarget=32'h42 and pcSrc=1. Expect imem_addr=32'h40 and misaligned high for exactly one cycle.
- Assert flush with flushPc=32'h100 while in WAIT, then return rvalid with rdata=32'hDEADBEEF. Expect the data discarded, instr_valid still 0, the next imem_addr=32'h100, and that instruction loaded with pc=32'h100.
- Assert reset while in WAIT. Expect the next cycle state=FETCH, imem_addr=RESET_PC, instr=32'h13, instr_valid=0. Separately, with pc=32'hFFFF_FFFC expect pcPlus4=0.
